// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the architectural
// HI/LO registers.
//   MULT/MULTU : radix-2 shift-add, one multiplier bit per cycle.
//   DIV/DIVU   : restoring division, one quotient bit per cycle.
//   MTHI/MTLO  : direct writes of wd into hi/lo. They are taken only while
//                the unit is idle and no start is being issued.
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   start, op       launch request; op 0=MULTU 1=MULT 2=DIVU 3=DIV
//   a, b            rs / rt operands, captured on the start edge
//   hi_we, lo_we    MTHI / MTLO write enables; wd is the write data
//   busy            operation in progress
//   done            one-cycle pulse after hi/lo take a result
//   hi, lo          architectural HI / LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]     opd;      // multiplicand (MUL) or divisor (DIV), magnitude
  logic [WIDTH-1:0]     a_orig;   // raw dividend, returned in hi on divide-by-zero
  logic [CW-1:0]        cnt;
  logic                 is_div, neg_q, neg_r, div_zero;
  logic                 take_start, take_mt;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     res_hi, res_lo;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x);
    // The most negative value maps onto itself, which is its correct magnitude
    // when read as unsigned.
    return (x < 0) ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = op[1] ? DIV : MUL;
      MUL:  if (cnt == LAST) state_nxt = FIX;
      DIV:  if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy       = (state != IDLE);
    take_start = (state == IDLE) && start;
    take_mt    = (state == IDLE) && !start;
  end

  // Iteration datapath
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd};
    prod      = neg_2w(acc, neg_q);
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_orig;
      res_lo = '1;
    end else begin
      res_hi = neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
      res_lo = neg_w(acc[WIDTH-1:0], neg_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      opd      <= '0;
      a_orig   <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (take_start) begin
        is_div   <= op[1];
        neg_q    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r    <= op[0] & a[WIDTH-1];
        div_zero <= op[1] & (b == '0);
        a_orig   <= a;
        cnt      <= '0;
        if (op[1]) begin
          acc <= {{WIDTH{1'b0}}, (op[0] ? abs_w(a) : a)};
          opd <= op[0] ? abs_w(b) : b;
        end else begin
          acc <= {{WIDTH{1'b0}}, (op[0] ? abs_w(b) : b)};
          opd <= op[0] ? abs_w(a) : a;
        end
      end else if (take_mt) begin
        if (hi_we) hi <= wd;
        if (lo_we) lo <= wd;
      end
      case (state)
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          // A clear borrow bit means the trial subtraction fits: keep it and shift in a 1.
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wd = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Launches one operation and watches until done (bounded). lat is the number
  // of edges after the start edge at which done was first seen; gaps counts
  // cycles where busy disagreed with "high until done, low at done".
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int gaps);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
    lat = 0; gaps = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        if (busy) gaps++;
        break;
      end
      if (!busy) gaps++;
      if (lat >= 60) break;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b want=0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu();
    int lat, gaps;
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, gaps);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL multu_latency got=%0d want=33", lat); end
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL multu_busy bad_cycles=%0d want=0", gaps); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got=%h want=fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got=%h want=00000001", lo); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got=%0b want=0", done); end
  endtask

  task automatic test_mult();
    int lat, gaps;
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, lat, gaps);
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got=%h want=ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg_lo got=%h want=ffffffeb", lo); end
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, lat, gaps);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mult_min_latency got=%0d want=33", lat); end
    n_cmp++; if (hi !== 32'h4000_0000) begin n_bad++; $display("FAIL mult_min_hi got=%h want=40000000", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL mult_min_lo got=%h want=0", lo); end
  endtask

  task automatic test_div();
    int lat, gaps;
    run_op(2'd2, 32'd100, 32'd7, lat, gaps);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divu_latency got=%0d want=33", lat); end
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got=%h want=0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi got=%h want=00000002", hi); end
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, lat, gaps);
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_lo got=%h want=fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_hi got=%h want=ffffffff", hi); end
  endtask

  task automatic test_div_corner();
    int lat, gaps;
    run_op(2'd2, 32'd5, 32'd0, lat, gaps);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divzero_latency got=%0d want=33", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divzero_lo got=%h want=ffffffff", lo); end
    n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL divzero_hi got=%h want=00000005", hi); end
    run_op(2'd3, 32'hFFFF_FFF9, 32'd0, lat, gaps);
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sdivzero_lo got=%h want=ffffffff", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL sdivzero_hi got=%h want=fffffff9", hi); end
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, gaps);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo got=%h want=80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi got=%h want=0", hi); end
  endtask

  task automatic test_busy_ignore();
    int lat, gaps;
    // Preload hi so a wrongly accepted MTHI while busy is visible.
    @(negedge clk); hi_we = 1'b1; wd = 32'h5555;
    @(negedge clk); hi_we = 1'b0;
    n_cmp++; if (hi !== 32'h5555) begin n_bad++; $display("FAIL mthi_preload got=%h want=00005555", hi); end
    @(negedge clk); op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    op = 2'd2; a = 32'd9; b = 32'd3; start = 1'b1; hi_we = 1'b1; wd = 32'h1234;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    n_cmp++; if (hi !== 32'h5555) begin n_bad++; $display("FAIL busy_mthi got=%h want=00005555", hi); end
    lat = 0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    // Started at E0, now 4 edges later; done lands 33 edges after E0.
    n_cmp++; if (lat !== 29) begin n_bad++; $display("FAIL busy_latency got=%0d want=29", lat); end
    n_cmp++; if (lo !== 32'd12) begin n_bad++; $display("FAIL busy_lo got=%h want=0000000c", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL busy_hi got=%h want=0", hi); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL no_queue_busy got=%0b want=0", busy); end
    hi_we = 1'b1; wd = 32'hABCD;
    @(posedge clk); #1 hi_we = 1'b0;
    n_cmp++; if (hi !== 32'hABCD) begin n_bad++; $display("FAIL idle_mthi got=%h want=0000abcd", hi); end
    @(negedge clk); op = 2'd0; a = 32'd2; b = 32'd3; start = 1'b1; lo_we = 1'b1; wd = 32'h7777;
    @(posedge clk); #1 start = 1'b0; lo_we = 1'b0;
    n_cmp++; if (lo !== 32'd12) begin n_bad++; $display("FAIL start_mtlo got=%h want=0000000c", lo); end
    lat = 0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lo !== 32'd6) begin n_bad++; $display("FAIL start_mtlo_result got=%h want=00000006", lo); end
  endtask

  task automatic test_reset_abort();
    int lat, gaps, pulses;
    @(negedge clk); op = 2'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%0b want=0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL abort_hi got=%h want=0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL abort_lo got=%h want=0", lo); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
    run_op(2'd2, 32'd1000, 32'd3, lat, gaps);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL post_reset_latency got=%0d want=33", lat); end
    n_cmp++; if (lo !== 32'd333) begin n_bad++; $display("FAIL post_reset_lo got=%h want=0000014d", lo); end
    n_cmp++; if (hi !== 32'd1) begin n_bad++; $display("FAIL post_reset_hi got=%h want=00000001", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_corner();
    test_busy_ignore();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
